boot_loader: RTL and testbench

- Serial-stream program loader that sits between a byte-wide host link (UART receiver or bench driver) and the instruction/data RAM write port.
- Assembles little-endian 32-bit words from an incoming byte stream and writes them to consecutive RAM addresses from 0.
- Checks a trailing checksum, then releases the CPU from reset.
- It is the writer for the memory image that the CPU later fetches and that the bench dumps at end of run.

---
 rtl/boot_loader_if.sv | 25 ++
 rtl/boot_loader.sv | 128 ++++++++++++
 tb/tb_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream host link, RAM write port and boot status for the program loader.
// The loader sits on the slave side; a host or bench driver takes the master side.
interface boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rstb;
  logic              done;
  logic              error;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_rstb, done, error
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rstb, done, error
  );
endinterface

// File: rtl/boot_loader.sv
// Serial program loader: 16-bit word count, little-endian 32-bit words written to RAM
// from address 0, then an 8-bit additive checksum that gates release of the CPU reset.
//
// state  | meaning
// LEN0   | waiting for word count low byte
// LEN1   | waiting for word count high byte
// DATA   | assembling data words and writing them to RAM
// CSUM   | waiting for checksum byte
// DONE   | load good, CPU released (terminal until reset)
// ERR    | length overflow or checksum mismatch (terminal until reset)
module boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rstb,
  input  logic        i_clk_en,
  boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         count;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          byte_idx;
  logic [7:0]          sum;
  logic [DATA_W-1:0]   word_sh;
  logic                we_pend;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accepting;
  logic                accept;
  logic [15:0]         count_full;
  logic                count_over;
  logic                last_word;
  logic                word_end;
  logic [DATA_W-1:0]   word_full;

  assign accepting  = (state == S_LEN0) || (state == S_LEN1) ||
                      (state == S_DATA) || (state == S_CSUM);
  // Ready is held low while reset is asserted so no byte is offered to a loader
  // that is about to be cleared.
  assign bus.rx_ready = i_rstb & i_clk_en & accepting;
  assign accept       = bus.rx_valid & bus.rx_ready;

  assign count_full = {bus.rx_data, count[7:0]};
  assign count_over = 32'(count_full) > MAX_WORDS;
  assign last_word  = 32'(word_idx) == (32'(count) - 32'd1);
  assign word_end   = byte_idx == 2'd3;
  assign word_full  = {bus.rx_data, word_sh[DATA_W-1:8]};

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LEN0: if (accept) state_nxt = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (count_over)              state_nxt = S_ERR;
          else if (count_full == 16'd0) state_nxt = S_CSUM;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA: if (accept && word_end && last_word) state_nxt = S_CSUM;
      S_CSUM: begin
        if (accept) state_nxt = (bus.rx_data == sum) ? S_DONE : S_ERR;
      end
      S_DONE: state_nxt = S_DONE;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      state     <= S_LEN0;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      sum       <= '0;
      word_sh   <= '0;
      we_pend   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (i_clk_en) begin
      state <= state_nxt;
      // A strobe held over a disabled stretch is seen on this enabled cycle.
      if (we_pend) we_pend <= 1'b0;
      if (accept) begin
        unique case (state)
          S_LEN0: count[7:0]  <= bus.rx_data;
          S_LEN1: count[15:8] <= bus.rx_data;
          S_DATA: begin
            word_sh  <= word_full;
            sum      <= sum + bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (word_end) begin
              we_pend   <= 1'b1;
              mem_addr  <= word_idx;
              mem_wdata <= word_full;
              word_idx  <= word_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_we    = we_pend & i_clk_en;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata[31:0];
  assign bus.cpu_rstb  = state == S_DONE;
  assign bus.done      = state == S_DONE;
  assign bus.error     = state == S_ERR;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: streams are scored by a byte-level model of the
// load format (count, words, checksum) and compared against captured RAM writes and flags.
module tb_boot_loader;

  localparam int ADDR_W = 10;
  localparam int MAXW   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic clk_en = 1'b1;

  boot_loader_if #(.ADDR_W(ADDR_W)) bus();

  boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .i_clk    (clk),
    .i_rstb   (rstb),
    .i_clk_en (clk_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        stream[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr.push_back(bus.mem_addr);
      got_data.push_back(bus.mem_wdata);
      n_checks++;
      if (clk_en !== 1'b1) begin
        n_fail++;
        $display("FAIL we_while_disabled: mem_we=%b clk_en=%b", bus.mem_we, clk_en);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(posedge clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      clk_en       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus.rx_valid && bus.rx_ready === 1'b1 && clk_en) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: byte=%02h not accepted, ready=%b", b, bus.rx_ready);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    clk_en       = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstb         = 1'b0;
    bus.rx_valid = 1'b0;
    clk_en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.cpu_rstb !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0 ||
        bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: cpu_rstb=%b done=%b error=%b ready=%b we=%b addr=%0d wdata=%h, required all 0",
               bus.cpu_rstb, bus.done, bus.error, bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    rstb = 1'b1;
    got_addr.delete();
    got_data.delete();
  endtask

  // Score the bytes held in `stream`: drive as many as the format lets the loader take,
  // then check writes, terminal flags one cycle after the deciding byte, and refusal after.
  task automatic run_stream(input string name, input bit gaps);
    int         cnt;
    int         n_acc;
    bit         exp_done;
    bit         exp_err;
    logic [7:0] s;
    logic [31:0] w;
    logic [31:0] exp_data[$];
    cnt = int'(stream[0]) + 256 * int'(stream[1]);
    if (cnt > MAXW) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      n_acc    = 2;
    end else begin
      s = 8'h00;
      for (int i = 0; i < cnt; i++) begin
        w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
        exp_data.push_back(w);
        for (int k = 0; k < 4; k++) s = s + stream[2+4*i+k];
      end
      exp_done = (stream[2+4*cnt] == s);
      exp_err  = !exp_done;
      n_acc    = 3 + 4 * cnt;
    end

    for (int i = 0; i < n_acc; i++) send_byte(stream[i], gaps);
    go_idle();
    @(negedge clk);
    n_checks++;
    if (bus.done !== exp_done || bus.error !== exp_err || bus.cpu_rstb !== exp_done) begin
      n_fail++;
      $display("FAIL %s_flags: done=%b error=%b cpu_rstb=%b, required done=%b error=%b cpu_rstb=%b",
               name, bus.done, bus.error, bus.cpu_rstb, exp_done, exp_err, exp_done);
    end

    n_checks++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 name, i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end

    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    @(negedge clk);
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ready_after: ready=%b, required 0", name, bus.rx_ready);
    end
    go_idle();
    @(negedge clk);
    n_checks++;
    if (bus.done !== exp_done || bus.error !== exp_err || got_data.size() != exp_data.size()) begin
      n_fail++;
      $display("FAIL %s_terminal_hold: done=%b error=%b writes=%0d, required done=%b error=%b writes=%0d",
               name, bus.done, bus.error, got_data.size(), exp_done, exp_err, exp_data.size());
    end
  endtask

  task automatic build_random(input int n, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    s = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      s = s + b;
    end
    stream.push_back(bad ? s + 8'(1 + $urandom_range(0, 254)) : s);
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    rstb   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== 32'h0 || bus.cpu_rstb !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b we=%b addr=%0d wdata=%h cpu_rstb=%b done=%b error=%b, required all 0",
               bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_rstb, bus.done, bus.error);
    end
    @(posedge clk); #1;
    rstb   = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: ready=%b, required 1", bus.rx_ready);
    end
    clk_en = 1'b0;
    #1;
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_clk_en_low: ready=%b, required 0", bus.rx_ready);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_good_load();
    do_reset();
    // The eight data bytes below sum to 0x44C, so the good checksum byte is 0x4C.
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    run_stream("good_load", 1'b0);
    n_checks++;
    if (got_data.size() != 2 || got_data[0] !== 32'h12345678 || got_data[1] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL good_load_words: got %0d words, required 12345678 DEADBEEF", got_data.size());
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h41};
    run_stream("bad_csum", 1'b0);
  endtask

  task automatic test_zero_length();
    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    run_stream("zero_good", 1'b0);
    do_reset();
    stream = '{8'h00, 8'h00, 8'h01};
    run_stream("zero_bad", 1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    stream = '{8'h01, 8'h04};
    run_stream("overflow", 1'b0);
    do_reset();
    build_random(MAXW, 1'b0);
    run_stream("max_count", 1'b0);
    n_checks++;
    if (got_addr.size() != MAXW || got_addr[got_addr.size()-1] !== ADDR_W'(MAXW - 1)) begin
      n_fail++;
      $display("FAIL max_last_addr: writes=%0d, required %0d ending at %0d", got_addr.size(), MAXW, MAXW - 1);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      build_random($urandom_range(1, 6), 1'b0);
      run_stream("b2b_cont", 1'b0);
    end
    for (int r = 0; r < 6; r++) begin
      do_reset();
      build_random($urandom_range(1, 8), r == 3);
      run_stream("b2b_gaps", 1'b1);
    end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    build_random(2, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
    go_idle();
    do_reset();
    stream = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    run_stream("restart", 1'b0);
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'h00000001 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_word: writes=%0d done=%b, required one write of 00000001 and done=1",
               got_data.size(), bus.done);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_zero_length();
    test_overflow();
    test_back_to_back();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
